// File: rtl/conv_ram_ctrl_pkg.sv
// ============================================================================
// conv_pkg : shared image geometry, pixel type and sequencer states
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package conv_pkg;

  localparam int IMG_DIM = 8;
  localparam int K       = 3;
  localparam int OUT_DIM = IMG_DIM - K + 1;
  localparam int NUM_PIX = IMG_DIM * IMG_DIM;

  // FETCH runs K issue phases plus one trailing capture phase.
  localparam logic [1:0] LAST_PHASE = 2'(K);

  typedef logic signed [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FETCH   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/conv_ram_ctrl_if.sv
// ============================================================================
// conv_ram_ctrl_if : pixel input, RAM-bank drive and window output bundle
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface conv_ram_ctrl_if;

  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ram_wr;
  logic [2:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [63:0] ram_dout;
  logic [71:0] win_data;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        win_valid;
  logic        win_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, in_data, in_valid, ram_dout, win_ready,
    output in_ready, ram_wr, ram_addr, ram_din,
           win_data, win_row, win_col, win_valid, busy, done
  );

  modport slave (
    output start, in_data, in_valid, ram_dout, win_ready,
    input  in_ready, ram_wr, ram_addr, ram_din,
           win_data, win_row, win_col, win_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/conv_ram_ctrl_win_assemble.sv
// ============================================================================
// conv_win_assemble : 3x3 window capture register fed one column per cycle
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module conv_win_assemble
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic [1:0]  cap_col,
  input  logic [2:0]  row_sel,
  input  logic [63:0] ram_dout,
  output logic [71:0] win_data
);

  pixel_t ram_px [IMG_DIM];

  for (genvar r = 0; r < IMG_DIM; r++) begin : g_unpack
    assign ram_px[r] = pixel_t'(ram_dout[8*r +: 8]);
  end

  // Window slot (i,j) takes RAM row_sel+i when column j is being captured.
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      pixel_t px_q;
      pixel_t px_d;

      always_comb begin
        px_d = px_q;
        if (cap_en && (cap_col == 2'(j))) begin
          px_d = ram_px[row_sel + 3'(i)];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          px_q <= '0;
        end else begin
          px_q <= px_d;
        end
      end

      assign win_data[8*(K*i+j) +: 8] = px_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_ram_ctrl.sv
// ============================================================================
// conv_ram_ctrl : loads an 8x8 image into the row RAM bank, then streams all
//                 36 valid 3x3 windows to the convolution engine.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module conv_ram_ctrl
  import conv_pkg::*;
#(
  parameter logic WR_ACTIVE = 1'b1
)(
  input  logic            clk,
  input  logic            rst,
  conv_ram_ctrl_if.master bus
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [2:0]  row_q,   row_d;
  logic [2:0]  col_q,   col_d;
  logic [1:0]  phase_q, phase_d;

  logic        load_fire;
  logic        cap_en;
  logic [1:0]  cap_col;
  logic [7:0]  wr_vec;
  logic [2:0]  addr;
  logic [71:0] win_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      phase_q <= phase_d;
    end
  end

  assign load_fire = (state_q == LOAD) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    phase_d = phase_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(NUM_PIX - 1)) begin
            state_d = FETCH;
            row_d   = '0;
            col_d   = '0;
            phase_d = '0;
          end
        end
      end

      FETCH: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == LAST_PHASE) begin
          state_d = PRESENT;
          phase_d = '0;
        end
      end

      PRESENT: begin
        if (bus.win_ready) begin
          phase_d = '0;
          if (col_q < 3'(OUT_DIM - 1)) begin
            col_d   = col_q + 3'd1;
            state_d = FETCH;
          end else if (row_q < 3'(OUT_DIM - 1)) begin
            col_d   = '0;
            row_d   = row_q + 3'd1;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write strobes are decoded straight from the handshake so a pixel lands
  // in the same cycle it is accepted.
  always_comb begin
    wr_vec = {IMG_DIM{~WR_ACTIVE}};
    if (load_fire) begin
      wr_vec[cnt_q[5:3]] = WR_ACTIVE;
    end

    addr = '0;
    if (state_q == LOAD) begin
      addr = cnt_q[2:0];
    end else if ((state_q == FETCH) && (phase_q < 2'(K))) begin
      addr = col_q + 3'(phase_q);
    end
  end

  // RAM read is registered, so the column issued in phase p arrives in p+1.
  assign cap_en  = (state_q == FETCH) && (phase_q != 2'd0);
  assign cap_col = phase_q - 2'd1;

  conv_win_assemble u_win (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .cap_col  (cap_col),
    .row_sel  (row_q),
    .ram_dout (bus.ram_dout),
    .win_data (win_data)
  );

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.ram_wr    = wr_vec;
  assign bus.ram_addr  = addr;
  assign bus.ram_din   = load_fire ? bus.in_data : 8'h00;
  assign bus.win_data  = win_data;
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;
  assign bus.win_valid = (state_q == PRESENT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_ram_ctrl.sv
// ============================================================================
// tb_conv_ram_ctrl : randomized bench with RAM-bank model and window model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_conv_ram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_ram_ctrl_if bus ();

  conv_ram_ctrl #(.WR_ACTIVE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Eight row RAMs with registered read.
  logic [7:0]  mem [8][8];
  logic [63:0] dout_q = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bus.ram_wr[i] === 1'b1) mem[i][bus.ram_addr] <= bus.ram_din;
      dout_q[8*i +: 8] <= mem[i][bus.ram_addr];
    end
  end
  assign bus.ram_dout = dout_q;

  int wr_seen = 0;
  always @(negedge clk) begin
    #2;
    if (bus.ram_wr !== 8'h00) wr_seen++;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  img [64];
  logic [71:0] first_win, last_win;

  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = img[(r+i)*8 + (c+j)];
    return w;
  endfunction

  task automatic load_image(input bit bursty);
    int p = 0;
    int budget = 0;
    int w0;
    bit v;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_to_ready: in_ready=%b want 1", bus.in_ready);
    end
    w0 = wr_seen;
    while (p < 64 && budget < 1000) begin
      v = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = img[p];
      #1;
      n_cmp++;
      if (v) begin
        if (bus.ram_wr !== 8'(1 << (p / 8)) || bus.ram_addr !== 3'(p % 8) ||
            bus.ram_din !== img[p]) begin
          n_err++;
          $display("FAIL load_write p=%0d: wr=%h addr=%0d din=%h want wr=%h addr=%0d din=%h",
                   p, bus.ram_wr, bus.ram_addr, bus.ram_din, 8'(1 << (p / 8)), p % 8, img[p]);
        end
        p++;
      end else if (bus.ram_wr !== 8'h00) begin
        n_err++;
        $display("FAIL load_gap p=%0d: wr=%h want 00", p, bus.ram_wr);
      end
      @(negedge clk);
      budget++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (p < 64) begin
      n_err++;
      $display("FAIL load_timeout: accepted=%0d want 64", p);
    end
    n_cmp++;
    if (wr_seen - w0 != 64) begin
      n_err++;
      $display("FAIL write_count: got=%0d want 64", wr_seen - w0);
    end
  endtask

  // mode 0: ready held high, 1: random ready, 2: 10-cycle stall at window (2,3)
  task automatic scan(input int mode, input bit noise);
    int idx = 0, k = 0, done_k = -1, first_k = -1, hold = 0, n_done = 0;
    logic [71:0] held = '0;
    bit rdy;
    while (k < 3000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(idx == 15 && hold < 10);
      endcase
      bus.win_ready = rdy;
      if (noise && done_k < 0) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
      end else begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
      end
      #1;
      if (noise && done_k < 0) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.ram_wr !== 8'h00) begin
          n_err++;
          $display("FAIL noise_ignored k=%0d: in_ready=%b wr=%h want 0/00", k, bus.in_ready, bus.ram_wr);
        end
      end
      if (bus.win_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        n_cmp++;
        if (idx >= 36) begin
          n_err++;
          $display("FAIL extra_window: got window %0d want at most 36", idx + 1);
        end else begin
          if (bus.win_row !== 3'(idx / 6) || bus.win_col !== 3'(idx % 6) ||
              bus.win_data !== model_win(idx / 6, idx % 6)) begin
            n_err++;
            $display("FAIL window idx=%0d: got (%0d,%0d) %h want (%0d,%0d) %h", idx,
                     bus.win_row, bus.win_col, bus.win_data, idx / 6, idx % 6,
                     model_win(idx / 6, idx % 6));
          end
          if (mode == 2 && idx == 15 && !rdy) begin
            if (hold > 0) begin
              n_cmp++;
              if (bus.win_data !== held) begin
                n_err++;
                $display("FAIL stall_stable: data=%h want %h", bus.win_data, held);
              end
            end
            held = bus.win_data;
            hold++;
          end
          if (rdy) begin
            if (idx == 0)  first_win = bus.win_data;
            if (idx == 35) last_win  = bus.win_data;
            idx++;
          end
        end
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL after_done: busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
      end
      if (done_k >= 0 && k >= done_k + 3) break;
      @(negedge clk);
      k++;
    end
    bus.win_ready = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    n_cmp++;
    if (done_k < 0) begin
      n_err++;
      $display("FAIL scan_timeout: done not seen, windows=%0d", idx);
    end
    n_cmp++;
    if (idx != 36 || n_done != 1) begin
      n_err++;
      $display("FAIL window_count: windows=%0d done_pulses=%0d want 36/1", idx, n_done);
    end
    if (mode == 2) begin
      n_cmp++;
      if (hold != 10) begin
        n_err++;
        $display("FAIL stall_cycles: got=%0d want 10", hold);
      end
    end
    if (mode == 0) begin
      n_cmp++;
      if (first_k != 4 || done_k != 180) begin
        n_err++;
        $display("FAIL scan_timing: first_valid=%0d done=%0d want 4/180", first_k, done_k);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.ram_wr, bus.ram_addr, bus.ram_din, bus.win_data, bus.win_row,
         bus.win_col, bus.win_valid, bus.busy, bus.done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: in_ready=%b wr=%h addr=%0d din=%h win=%h rc=(%0d,%0d) v=%b busy=%b done=%b want all 0",
               bus.in_ready, bus.ram_wr, bus.ram_addr, bus.ram_din, bus.win_data,
               bus.win_row, bus.win_col, bus.win_valid, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.ram_wr !== 8'h00) begin
      n_err++;
      $display("FAIL idle_ignores_valid: busy=%b in_ready=%b wr=%h want 0/0/00",
               bus.busy, bus.in_ready, bus.ram_wr);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_full_ramp;
    for (int p = 0; p < 64; p++) img[p] = 8'(p);
    load_image(1'b0);
    scan(0, 1'b0);
    n_cmp++;
    if (first_win !== {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}) begin
      n_err++;
      $display("FAIL ramp_first: got %h want 12111 0a0908020100 pattern", first_win);
    end
    n_cmp++;
    if (last_win !== {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45}) begin
      n_err++;
      $display("FAIL ramp_last: got %h want 3f3e3d37363 52f2e2d pattern", last_win);
    end
  endtask

  task automatic test_sign_extremes;
    for (int p = 0; p < 64; p++) img[p] = 8'($urandom);
    img[0]  = 8'h80;
    img[63] = 8'h7F;
    load_image(1'b1);
    scan(1, 1'b0);
    n_cmp++;
    if (first_win[7:0] !== 8'h80 || last_win[71:64] !== 8'h7F) begin
      n_err++;
      $display("FAIL sign_extremes: slot0=%h slot8=%h want 80/7f", first_win[7:0], last_win[71:64]);
    end
  endtask

  task automatic test_backpressure;
    for (int p = 0; p < 64; p++) img[p] = 8'($urandom);
    load_image(1'b0);
    scan(2, 1'b0);
  endtask

  task automatic test_bursty_input;
    int bad = 0;
    for (int p = 0; p < 64; p++) img[p] = 8'($urandom);
    load_image(1'b1);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (mem[i][j] !== img[8*i + j]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ram_contents: wrong_entries=%0d want 0", bad);
    end
    scan(1, 1'b0);
  endtask

  task automatic test_ignore_when_busy;
    for (int p = 0; p < 64; p++) img[p] = 8'($urandom);
    load_image(1'b0);
    scan(1, 1'b1);
  endtask

  task automatic test_reset_mid_fetch;
    int budget = 0;
    bit found = 1'b0;
    for (int p = 0; p < 64; p++) img[p] = 8'($urandom);
    load_image(1'b1);
    while (budget < 500) begin
      bus.win_ready = 1'b1;
      #1;
      if (bus.win_row === 3'd1 && bus.win_col === 3'd1 && bus.busy === 1'b1 &&
          bus.win_valid === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reach_fetch_1_1: not reached within %0d cycles", budget);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.ram_wr, bus.ram_addr, bus.ram_din, bus.win_data, bus.win_row,
         bus.win_col, bus.win_valid, bus.busy, bus.done} !== '0) begin
      n_err++;
      $display("FAIL async_reset: wr=%h addr=%0d win=%h rc=(%0d,%0d) v=%b busy=%b want all 0",
               bus.ram_wr, bus.ram_addr, bus.win_data, bus.win_row, bus.win_col,
               bus.win_valid, bus.busy);
    end
    bus.win_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.win_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: busy=%b win_valid=%b want 0/0", bus.busy, bus.win_valid);
    end
    for (int p = 0; p < 64; p++) img[p] = 8'($urandom);
    load_image(1'b0);
    scan(1, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.win_ready = 1'b0;
    test_reset();
    test_full_ramp();
    test_sign_extremes();
    test_backpressure();
    test_bursty_input();
    test_ignore_when_busy();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
